// File: rtl/param_frame_decoder.sv
// Framed serial parameter-write decoder: SYNC, IDX, DLO, DHI, CHK -> one-cycle load strobe.
// Optional ack byte transmitter enabled by defining PARAM_ACK_EN.
module param_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 50000,
    parameter int         MAX_INDEX = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        get_param_st,
    output logic [7:0]  param_index,
    output logic [15:0] param_data,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy
`ifdef PARAM_ACK_EN
    ,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy
`endif
);

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);
    localparam logic [7:0]  MAX_IDX      = 8'(MAX_INDEX);
    localparam logic [7:0]  ACK_ERR      = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        GET_IDX,
        GET_DLO,
        GET_DHI,
        GET_CHK
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  dlo_reg, dlo_next;
    logic [7:0]  dhi_reg, dhi_next;
    logic [15:0] timer_reg, timer_next;
    logic [7:0]  chk_sum;
    logic        accept;
    logic        reject;

    assign chk_sum = idx_reg + dlo_reg + dhi_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 8'd0;
            dlo_reg   <= 8'd0;
            dhi_reg   <= 8'd0;
            timer_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dlo_reg   <= dlo_next;
            dhi_reg   <= dhi_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dlo_next   = dlo_reg;
        dhi_next   = dhi_reg;
        timer_next = timer_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        if (state_reg == IDLE) begin
            timer_next = 16'd0;
            if (rx_valid && rx_data == SYNC_BYTE) begin
                state_next = GET_IDX;
                timer_next = TIMEOUT_LOAD;
            end
        end else if (rx_valid) begin
            // A byte always wins over a coinciding timer expiry.
            timer_next = TIMEOUT_LOAD;
            case (state_reg)
                GET_IDX: begin
                    idx_next   = rx_data;
                    state_next = GET_DLO;
                end
                GET_DLO: begin
                    dlo_next   = rx_data;
                    state_next = GET_DHI;
                end
                GET_DHI: begin
                    dhi_next   = rx_data;
                    state_next = GET_CHK;
                end
                GET_CHK: begin
                    state_next = IDLE;
                    timer_next = 16'd0;
                    if (rx_data == chk_sum && idx_reg <= MAX_IDX) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = 16'd0;
                end
            endcase
        end else if (timer_reg <= 16'd1) begin
            state_next = IDLE;
            timer_next = 16'd0;
            reject     = 1'b1;
        end else begin
            timer_next = timer_reg - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            get_param_st <= 1'b0;
            param_index  <= 8'd0;
            param_data   <= 16'd0;
            frame_err    <= 1'b0;
            err_cnt      <= 8'd0;
            busy         <= 1'b0;
        end else begin
            get_param_st <= accept;
            frame_err    <= reject;
            busy         <= (state_next != IDLE);
            if (accept) begin
                param_index <= idx_reg;
                param_data  <= {dhi_reg, dlo_reg};
            end
            if (reject && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef PARAM_ACK_EN
    logic       pend_reg;
    logic [7:0] pend_data_reg;

    assign tx_start = pend_reg & ~tx_busy;
    assign tx_data  = pend_data_reg;

    // A fresh outcome overwrites whatever ack is still waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg      <= 1'b0;
            pend_data_reg <= 8'd0;
        end else if (accept) begin
            pend_reg      <= 1'b1;
            pend_data_reg <= idx_reg;
        end else if (reject) begin
            pend_reg      <= 1'b1;
            pend_data_reg <= ACK_ERR;
        end else if (tx_start) begin
            pend_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_param_frame_decoder.sv
// Scoreboard bench for param_frame_decoder: frame-level reference model feeds an expectation
// queue, an independent monitor compares every strobe / error pulse and the busy flag.
module tb_param_frame_decoder;

    localparam int         TMO  = 10;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXI = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        get_param_st;
    logic [7:0]  param_index;
    logic [15:0] param_data;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    param_frame_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO), .MAX_INDEX(MAXI)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .get_param_st(get_param_st), .param_index(param_index), .param_data(param_data),
        .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          good;
        logic [7:0]  idx;
        logic [15:0] data;
        logic [7:0]  ecnt;
        int          cyc;
    } exp_t;

    exp_t       sbq[$];
    int         busy_at[int];
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;

    // reference model state
    logic [7:0]  fr[$];
    int          quiet = 0;
    logic [7:0]  m_idx = 8'd0;
    logic [15:0] m_data = 16'd0;
    int          m_ecnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_outcome(input bit good, input int c);
        exp_t e;
        e.good = good;
        e.idx  = m_idx;
        e.data = m_data;
        e.ecnt = 8'(m_ecnt);
        e.cyc  = c + 1;
        sbq.push_back(e);
    endtask

    // Frame-level model: collects bytes of one frame, counts silent cycles.
    task automatic model(input bit v, input logic [7:0] d, input int c);
        int s;
        if (v) begin
            if (fr.size() == 0) begin
                if (d == SYNC) fr.push_back(d);
            end else begin
                fr.push_back(d);
            end
            quiet = 0;
            if (fr.size() == 5) begin
                s = (int'(fr[1]) + int'(fr[2]) + int'(fr[3])) % 256;
                if (s == int'(fr[4]) && int'(fr[1]) <= MAXI) begin
                    m_idx  = fr[1];
                    m_data = {fr[3], fr[2]};
                    push_outcome(1'b1, c);
                end else begin
                    if (m_ecnt < 255) m_ecnt++;
                    push_outcome(1'b0, c);
                end
                fr.delete();
            end
        end else if (fr.size() != 0) begin
            quiet++;
            if (quiet == TMO) begin
                if (m_ecnt < 255) m_ecnt++;
                push_outcome(1'b0, c);
                fr.delete();
            end
        end
        busy_at[c + 1] = (fr.size() != 0) ? 1 : 0;
    endtask

    task automatic drive_cycle(input bit v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        model(v, d, cyc);
    endtask

    task automatic send_frame(input logic [7:0] i, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [7:0] ck, input int gap);
        logic [7:0] b[5];
        b[0] = SYNC; b[1] = i; b[2] = lo; b[3] = hi; b[4] = ck;
        for (int k = 0; k < 5; k++) begin
            repeat (gap) drive_cycle(1'b0, 8'd0);
            drive_cycle(1'b1, b[k]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 8'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_strobe"}, get_param_st, 0);
        chk({tag, "_index"}, param_index, 0);
        chk({tag, "_data"}, param_data, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_errcnt"}, err_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("missing_pulse_cycle", 32'(cyc), 32'(sbq[0].cyc));
                void'(sbq.pop_front());
            end
            if (get_param_st || frame_err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {get_param_st, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("strobe", get_param_st, e.good);
                    chk("frame_err", frame_err, !e.good);
                    chk("param_index", param_index, e.idx);
                    chk("param_data", param_data, e.data);
                    chk("err_cnt", err_cnt, e.ecnt);
                end
            end
            if (busy_at.exists(cyc)) chk("busy", busy, busy_at[cyc]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ri, rlo, rhi, rck;
        int r;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // good frame
        send_frame(8'h05, 8'h34, 8'h12, 8'h4B, 0);
        idle(3);
        chk("good_index", param_index, 8'h05);
        chk("good_data", param_data, 16'h1234);
        // bad checksum, illegal index
        send_frame(8'h05, 8'h34, 8'h12, 8'h4C, 0);
        idle(3);
        chk("badchk_errcnt", err_cnt, 8'd1);
        chk("badchk_hold", param_data, 16'h1234);
        send_frame(8'h13, 8'h00, 8'h00, 8'h13, 1);
        idle(3);
        // garbage before sync
        drive_cycle(1'b1, 8'h00);
        drive_cycle(1'b1, 8'hFF);
        drive_cycle(1'b1, 8'h5A);
        send_frame(8'h01, 8'hFF, 8'hFF, 8'hFF, 0);
        idle(3);
        chk("garbage_data", param_data, 16'hFFFF);
        // timeout, then byte exactly at expiry
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h02);
        idle(TMO + 3);
        chk("timeout_errcnt", err_cnt, 8'd3);
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h02);
        idle(TMO - 1);
        drive_cycle(1'b1, 8'h34);
        drive_cycle(1'b1, 8'h12);
        drive_cycle(1'b1, 8'h48);
        idle(3);
        chk("expiry_byte_data", param_data, 16'h1234);
        // back-to-back frames
        send_frame(8'h03, 8'h11, 8'h22, 8'h36, 0);
        send_frame(8'h12, 8'hA5, 8'hA5, 8'h5C, 0);
        idle(3);

        // randomized frames
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++)
                    drive_cycle(1'b1, 8'($urandom_range(0, 255)));
            end
            ri  = 8'($urandom_range(0, 24));
            rlo = 8'($urandom_range(0, 255));
            rhi = 8'($urandom_range(0, 255));
            rck = ri + rlo + rhi;
            if ($urandom_range(0, 4) == 0) rck = rck ^ 8'(1 << $urandom_range(0, 7));
            r = int'($urandom_range(0, 19));
            send_frame(ri, rlo, rhi, rck,
                       (r < 14) ? 0 : (r == 18) ? TMO - 1 : (r == 19) ? TMO : r - 13);
        end
        idle(TMO + 2);

        // saturate the error counter
        for (int n = 0; n < 260; n++) send_frame(8'h30, 8'h00, 8'h00, 8'h30, 0);
        idle(3);
        chk("errcnt_saturated", err_cnt, 8'hFF);

        // reset mid-frame
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h07);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        fr.delete();
        quiet = 0;
        m_idx = 8'd0;
        m_data = 16'd0;
        m_ecnt = 0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(8'h07, 8'h01, 8'h02, 8'h0A, 0);
        idle(TMO + 3);
        chk("after_reset_data", param_data, 16'h0201);
        chk("scoreboard_drained", 32'(sbq.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/param_frame_decoder.md
Name: param_frame_decoder

Overview:
Serial command decoder that drives the servo regulator's parameter-load port. It takes bytes from the UART receiver and assembles framed parameter writes. Each validated frame becomes a single-cycle get_param_st strobe with param_index and param_data. It sits between the UART RX and the regulator's get_param_st / param_index / param_data inputs.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 50000, inter-byte timeout in clk cycles (1..65535).
MAX_INDEX, 18, highest legal parameter index; larger indices are rejected.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset.
rx_data  input  8  received byte, valid only when rx_valid=1.
rx_valid  input  1  one-cycle strobe, one byte per strobe.
get_param_st  output  1  one-cycle load strobe to the regulator.
param_index  output  8  parameter index; held between strobes.
param_data  output  16  parameter value; held between strobes.
frame_err  output  1  one-cycle pulse per rejected frame.
err_cnt  output  8  saturating count of rejected frames.
busy  output  1  high while a frame is partially received (state != IDLE).

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, internal byte and timer registers 0.
- Frame format is 5 bytes: SYNC, IDX, DLO, DHI, CHK.
  - CHK = (IDX + DLO + DHI) mod 256, an 8-bit wrapping sum.
  - param_data = {DHI, DLO}.
- FSM states: IDLE, GET_IDX, GET_DLO, GET_DHI, GET_CHK. A state advances only on rx_valid.
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> GET_IDX. Any other byte is discarded silently (no frame_err).
  - GET_IDX -> GET_DLO -> GET_DHI -> GET_CHK, each latching its byte into a shadow register.
  - Payload bytes equal to SYNC_BYTE are data and do not resync.
  - GET_CHK with rx_valid -> IDLE on the same edge.
- Accepting the CHK byte:
  - Checksum matches and IDX <= MAX_INDEX: param_index and param_data load from the shadow registers, and get_param_st=1 for exactly the next cycle. Latency is 1 clk after the CHK byte's rx_valid cycle.
  - Checksum wrong or IDX > MAX_INDEX: frame_err=1 for one cycle, err_cnt increments (saturates at 255, no wrap). param_index, param_data and get_param_st are unchanged or 0.
- param_index and param_data change only in the same cycle get_param_st asserts, and hold otherwise.
- Back-to-back frames: a SYNC byte arriving in the cycle right after CHK is accepted normally. There are no dead cycles.
- Timeout:
  - A 16-bit timer loads TIMEOUT on every accepted byte in a non-IDLE state.
  - It decrements each non-IDLE cycle that has no rx_valid.
  - When it reaches 0: state -> IDLE, frame_err pulse, err_cnt increments, no strobe.
  - If rx_valid and expiry coincide, the byte wins: it is processed and there is no timeout.
  - The timer is inactive in IDLE.
- busy = (state != IDLE), registered.
- Reset mid-frame: partial frame discarded, no strobe, err_cnt cleared.

Optional Feature:
Macro PARAM_ACK_EN.
- Defined: adds ports tx_data[7:0] (output), tx_start (output, 1-cycle pulse) and tx_busy (input).
  - After each frame outcome, an ack byte is queued: the accepted IDX on success, 8'hEE on any error (checksum, index or timeout).
  - There is a one-entry pending register; a newer ack overwrites a pending one.
  - tx_start pulses on the first cycle the entry is pending and tx_busy=0; tx_data is stable during that cycle. The pending entry clears on tx_start.
  - Reset values: tx_start=0, tx_data=0, nothing pending.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Good frame: bytes A5 05 34 12 4B -> one get_param_st pulse 1 clk after the 4B byte, param_index=05, param_data=0x1234, frame_err never asserts.
- Bad checksum: A5 05 34 12 4C -> frame_err pulse, err_cnt=1, no strobe, param_index/param_data keep their prior values.
- Illegal index: A5 13 00 00 13 -> rejected (0x13 > 18), frame_err, err_cnt increments, no strobe.
- Garbage before sync: 00 FF 5A, then A5 01 FF FF FF -> no frame_err for the garbage, then a strobe with index=01, data=0xFFFF.
- Timeout (TIMEOUT=10): A5 02, then no rx_valid -> frame_err on the 10th idle cycle, busy falls. A later good frame decodes normally. A byte arriving exactly at expiry is consumed with no error.
- Reset mid-frame / back-to-back: rst after A5 07 -> outputs 0. Two frames sent back-to-back with zero gap -> two strobes 5 clk apart, each with correct data.
